smem_banked_array: RTL and testbench
====================================

Name: smem_banked_array

Overview:
- Parametrised successor to the single shared-memory bank: NUM_BANKS interleaved banks serve a NUM_LANES request bundle from one GPU warp.
- Detects bank conflicts and serialises conflicting lanes over multiple passes.
- Broadcasts reads when several lanes hit the same address, and resolves same-address writes.
- Sits between the core load/store unit and the shared-memory storage; one bundle in flight at a time.

Parameters:
DATA_W, 8, bits per word
ADDR_W, 8, word address width per lane (bank = low log2(NUM_BANKS) bits, row = remaining bits)
NUM_BANKS, 4, number of banks; power of two, at least 2
NUM_LANES, 4, lanes per request bundle

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  bundle offered
req_ready  out  1  block can accept a bundle
req_write  in  1  1 = whole bundle is a write, 0 = read
req_mask  in  NUM_LANES  per-lane active bit
req_addr  in  NUM_LANES*ADDR_W  lane i at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_LANES*DATA_W  write data, lane i at [i*DATA_W +: DATA_W]
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  NUM_LANES*DATA_W  read data, same packing; held until the next completion
pass_count  out  $clog2(NUM_LANES)+1  passes used by the completed bundle

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset asserted forces: state IDLE, req_ready=0, rsp_valid=0, rsp_data=0, pass_count=0, pending=0.
- Memory contents are not reset.
- Bank writes are suppressed at any edge while reset is low.
- FSM states: IDLE, ISSUE, DRAIN.
- req_ready is 1 only when state is IDLE and reset is deasserted.
- Accept happens on the edge with req_valid && req_ready (edge E0):
  - latch write flag, addresses, data;
  - pending <= req_mask;
  - clear lane result buffers to 0;
  - go to ISSUE, or to DRAIN if the mask is 0.
- ISSUE, one pass per cycle. For each bank:
  - winner = lowest-index pending lane mapped to that bank;
  - every pending lane with identical full address is served in the same pass;
  - read: bank read of winner row, data captured into all served lanes' buffers at the next edge;
  - write: the highest-index served lane's data is written (same-address write: last lane wins);
  - served lanes are cleared from pending; pass counter increments.
- When pending becomes 0 after a pass, go to DRAIN.
- DRAIN:
  - lasts one cycle to capture the final synchronous read data;
  - at its closing edge: rsp_valid<=1, pass_count<=passes, state<=IDLE.
- Bank read latency is 1 cycle (synchronous read).
- Timing: with P passes, rsp_valid rises at edge E0+P+1 and falls at the next edge.
- Mask 0: P=0, rsp_valid rises at E1, no bank access.
- Inactive lanes and all lanes of a write bundle return 0 in rsp_data.
- A new bundle may be accepted in the cycle rsp_valid is high; rsp_data is stable through that cycle.
- Reset mid-operation aborts the bundle, and no rsp_valid is produced for it. Writes committed at earlier edges persist.
- pass_count range: 0..NUM_LANES, so $clog2(NUM_LANES)+1 bits are required.
- Reading an address never written returns undefined data; the bench must not check it.

Decomposition:
- Package smem_pkg:
  - BANK_SEL_W = $clog2(NUM_BANKS);
  - ROW_W = ADDR_W - BANK_SEL_W;
  - state enum {IDLE, ISSUE, DRAIN};
  - lane-slice helper functions for packed buses.
- One sub-module, smem_bank_ram: DATA_W x 2**ROW_W single-port RAM with write enable and 1-cycle synchronous read.
  - Instantiated NUM_BANKS times via generate.
- Conflict selection (per-bank lowest-pending-lane priority encoder plus same-address match) stays in the top module.

Test Plan (NUM_BANKS=4, NUM_LANES=4, DATA_W=8, ADDR_W=8):
1. Conflict-free: write addrs 0x00/0x01/0x02/0x03 data A0/A1/A2/A3 mask 1111 -> rsp_valid at E2, pass_count=1, rsp_data=0. Then read same addrs -> rsp_data={A3,A2,A1,A0}, pass_count=1.
2. Full conflict: after writing 0x00,0x04,0x08,0x0C with 10,20,30,40, read them -> pass_count=4, rsp_valid at E5, rsp_data={40,30,20,10}, req_ready=0 for E1..E5.
3. Broadcast: write 0x10=5A, then all four lanes read 0x10 -> pass_count=1, every lane 5A.
4. Same-address write: lanes 0..3 write 0x20 with 11/22/33/44 -> pass_count=1. Read 0x20 -> 44.
5. Masks: mask 0000 -> rsp_valid at E1, pass_count=0, rsp_data=0. Read mask 0101 -> lanes 1 and 3 return 00.
6. Reset mid-op: write 0x30/0x34/0x38/0x3C data 01/02/03/04, pull reset low between E2 and E3 for 2 cycles.
   - Required: no rsp_valid; req_ready=0 while low.
   - Readback: 0x30=01, 0x34=02 (0x38/0x3C not written).

Source files
------------

// File: rtl/smem_pkg.sv
// Shared types and helpers for the banked shared-memory array.
// Default geometry lives here; the top recomputes widths from its own parameters.
package smem_pkg;

   localparam int unsigned DEF_DATA_W    = 8;
   localparam int unsigned DEF_ADDR_W    = 8;
   localparam int unsigned DEF_NUM_BANKS = 4;
   localparam int unsigned DEF_NUM_LANES = 4;

   localparam int unsigned BANK_SEL_W = $clog2(DEF_NUM_BANKS);
   localparam int unsigned ROW_W      = DEF_ADDR_W - BANK_SEL_W;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StDrain
   } state_e;

   // Bit offset of a lane's field inside a packed per-lane bus.
   function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
      return lane * width;
   endfunction

endpackage

// File: rtl/smem_banked_array_if.sv
// Request/response bundle between the load/store unit (master) and the banked array (slave).
interface smem_banked_array_if #(
   parameter int unsigned DATA_W    = smem_pkg::DEF_DATA_W,
   parameter int unsigned ADDR_W    = smem_pkg::DEF_ADDR_W,
   parameter int unsigned NUM_LANES = smem_pkg::DEF_NUM_LANES
) ();

   localparam int unsigned PcW = $clog2(NUM_LANES) + 1;

   logic                          req_valid;
   logic                          req_ready;
   logic                          req_write;
   logic [NUM_LANES-1:0]          req_mask;
   logic [NUM_LANES*ADDR_W-1:0]   req_addr;
   logic [NUM_LANES*DATA_W-1:0]   req_data;
   logic                          rsp_valid;
   logic [NUM_LANES*DATA_W-1:0]   rsp_data;
   logic [PcW-1:0]                pass_count;

   modport master (
      output req_valid, req_write, req_mask, req_addr, req_data,
      input  req_ready, rsp_valid, rsp_data, pass_count
   );

   modport slave (
      input  req_valid, req_write, req_mask, req_addr, req_data,
      output req_ready, rsp_valid, rsp_data, pass_count
   );

endinterface

// File: rtl/smem_bank_ram.sv
// One shared-memory bank: single-port RAM with write enable and 1-cycle synchronous read.
module smem_bank_ram #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ROW_W  = 6
) (
   input  logic              clk_i,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [ROW_W-1:0]  addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ROW_W];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            mem_q[addr_i] <= wdata_i;
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/smem_banked_array.sv
// Banked shared memory serving one warp bundle at a time; bank conflicts are serialised over
// passes, same-address reads broadcast and same-address writes resolve to the highest lane.
module smem_banked_array
   import smem_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter int unsigned NUM_BANKS = DEF_NUM_BANKS,
   parameter int unsigned NUM_LANES = DEF_NUM_LANES
) (
   input logic                clock,
   input logic                reset,
   smem_banked_array_if.slave bus
);

   localparam int unsigned BankSelW = $clog2(NUM_BANKS);
   localparam int unsigned RowW     = ADDR_W - BankSelW;
   localparam int unsigned PcW      = $clog2(NUM_LANES) + 1;

   state_e                       state_q, state_d;
   logic                         write_q, write_d;
   logic [NUM_LANES-1:0]         pending_q, pending_d;
   logic [NUM_LANES-1:0]         cap_q, cap_d;
   logic [PcW-1:0]               passes_q, passes_d;
   logic                         rsp_valid_q, rsp_valid_d;
   logic [PcW-1:0]               pass_count_q, pass_count_d;
   logic [NUM_LANES*DATA_W-1:0]  rsp_data_q, rsp_data_d;
   logic [ADDR_W-1:0]            addr_q [NUM_LANES];
   logic [ADDR_W-1:0]            addr_d [NUM_LANES];
   logic [DATA_W-1:0]            wdata_q [NUM_LANES];
   logic [DATA_W-1:0]            wdata_d [NUM_LANES];
   logic [DATA_W-1:0]            buf_q [NUM_LANES];
   logic [DATA_W-1:0]            buf_d [NUM_LANES];

   logic [BankSelW-1:0]          lane_bank [NUM_LANES];
   logic [NUM_LANES-1:0]         served;
   logic [NUM_BANKS-1:0]         found;
   logic [ADDR_W-1:0]            win_addr [NUM_BANKS];
   logic [NUM_BANKS-1:0]         bank_en;
   logic [NUM_BANKS-1:0]         bank_we;
   logic [RowW-1:0]              bank_row [NUM_BANKS];
   logic [DATA_W-1:0]            bank_wdata [NUM_BANKS];
   logic [DATA_W-1:0]            bank_rdata [NUM_BANKS];

   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         lane_bank[i] = addr_q[i][BankSelW-1:0];
      end
   end

   // Per bank: the lowest pending lane wins, and every pending lane sharing its full
   // address rides along in the same pass.
   always_comb begin
      found      = '0;
      served     = '0;
      bank_en    = '0;
      bank_we    = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         win_addr[b]   = '0;
         bank_wdata[b] = '0;
         bank_row[b]   = '0;
      end
      for (int b = 0; b < NUM_BANKS; b++) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (pending_q[i] && (lane_bank[i] == BankSelW'(b)) && !found[b]) begin
               found[b]    = 1'b1;
               win_addr[b] = addr_q[i];
            end
         end
      end
      for (int i = 0; i < NUM_LANES; i++) begin
         served[i] = pending_q[i] && (addr_q[i] == win_addr[lane_bank[i]]);
      end
      for (int b = 0; b < NUM_BANKS; b++) begin
         // Ascending scan leaves the highest served lane's data in place.
         for (int i = 0; i < NUM_LANES; i++) begin
            if (served[i] && (lane_bank[i] == BankSelW'(b))) begin
               bank_wdata[b] = wdata_q[i];
            end
         end
         bank_en[b]  = found[b] && (state_q == StIssue);
         bank_we[b]  = bank_en[b] && write_q && reset;
         bank_row[b] = win_addr[b][ADDR_W-1:BankSelW];
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      smem_bank_ram #(
         .DATA_W (DATA_W),
         .ROW_W  (RowW)
      ) u_ram (
         .clk_i   (clock),
         .en_i    (bank_en[b]),
         .we_i    (bank_we[b]),
         .addr_i  (bank_row[b]),
         .wdata_i (bank_wdata[b]),
         .rdata_o (bank_rdata[b])
      );
   end

   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      pending_d    = pending_q;
      cap_d        = '0;
      passes_d     = passes_q;
      rsp_valid_d  = 1'b0;
      pass_count_d = pass_count_q;
      rsp_data_d   = rsp_data_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      buf_d        = buf_q;

      // Read data of the previous pass lands now, one cycle after the bank access.
      for (int i = 0; i < NUM_LANES; i++) begin
         if (cap_q[i]) begin
            buf_d[i] = bank_rdata[lane_bank[i]];
         end
      end

      unique case (state_q)
         StIdle: begin
            if (bus.req_valid && bus.req_ready) begin
               write_d   = bus.req_write;
               pending_d = bus.req_mask;
               passes_d  = '0;
               for (int i = 0; i < NUM_LANES; i++) begin
                  addr_d[i]  = bus.req_addr[lane_lsb(i, ADDR_W) +: ADDR_W];
                  wdata_d[i] = bus.req_data[lane_lsb(i, DATA_W) +: DATA_W];
                  buf_d[i]   = '0;
               end
               state_d = (bus.req_mask == '0) ? StDrain : StIssue;
            end
         end
         StIssue: begin
            pending_d = pending_q & ~served;
            cap_d     = write_q ? '0 : served;
            passes_d  = passes_q + PcW'(1);
            if (pending_d == '0) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            rsp_valid_d  = 1'b1;
            pass_count_d = passes_q;
            for (int i = 0; i < NUM_LANES; i++) begin
               rsp_data_d[lane_lsb(i, DATA_W) +: DATA_W] = buf_d[i];
            end
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         write_q      <= 1'b0;
         pending_q    <= '0;
         cap_q        <= '0;
         passes_q     <= '0;
         rsp_valid_q  <= 1'b0;
         pass_count_q <= '0;
         rsp_data_q   <= '0;
         addr_q       <= '{default: '0};
         wdata_q      <= '{default: '0};
         buf_q        <= '{default: '0};
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         pending_q    <= pending_d;
         cap_q        <= cap_d;
         passes_q     <= passes_d;
         rsp_valid_q  <= rsp_valid_d;
         pass_count_q <= pass_count_d;
         rsp_data_q   <= rsp_data_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         buf_q        <= buf_d;
      end
   end

   assign bus.req_ready  = (state_q == StIdle) && reset;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.pass_count = pass_count_q;

endmodule

// File: tb/tb_smem_banked_array.sv
// Directed bench for smem_banked_array: table of bundles with hand-computed results plus
// hand-written back-to-back and mid-operation reset sequences.
module tb_smem_banked_array;

   logic clock;
   logic reset;

   smem_banked_array_if #(.DATA_W(8), .ADDR_W(8), .NUM_LANES(4)) bus_if ();

   smem_banked_array #(
      .DATA_W    (8),
      .ADDR_W    (8),
      .NUM_BANKS (4),
      .NUM_LANES (4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic        wr;
      logic [3:0]  mask;
      logic [31:0] addr;   // {lane3, lane2, lane1, lane0}
      logic [31:0] data;
      int          lat;    // edges after the accept edge until rsp_valid
      logic [2:0]  pc;
      logic [31:0] rd;
   } vec_t;

   int n_cmp;
   int n_fail;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, got, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus_if.req_valid = 1'b1;
      bus_if.req_write = v.wr;
      bus_if.req_mask  = v.mask;
      bus_if.req_addr  = v.addr;
      bus_if.req_data  = v.data;
   endtask

   task automatic accept();
      @(posedge clock);
      #1;
      bus_if.req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat, output logic [31:0] rd, output logic [2:0] pc,
                           output bit ready_ok);
      lat      = 0;
      rd       = '0;
      pc       = '0;
      ready_ok = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clock);
         #1;
         if (bus_if.rsp_valid) begin
            lat = k;
            rd  = bus_if.rsp_data;
            pc  = bus_if.pass_count;
            break;
         end
         if (bus_if.req_ready) ready_ok = 1'b0;
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int          lat;
      logic [31:0] rd;
      logic [2:0]  pc;
      bit          rok;
      check({tag, "_ready_before"}, 32'(bus_if.req_ready), 32'd1);
      drive(v);
      accept();
      wait_rsp(lat, rd, pc, rok);
      check({tag, "_latency"}, 32'(lat), 32'(v.lat));
      check({tag, "_pass_count"}, 32'(pc), 32'(v.pc));
      check({tag, "_rsp_data"}, rd, v.rd);
      check({tag, "_ready_low_while_busy"}, 32'(rok), 32'd1);
      check({tag, "_ready_after"}, 32'(bus_if.req_ready), 32'd1);
      @(posedge clock);
      #1;
      check({tag, "_valid_pulse"}, 32'(bus_if.rsp_valid), 32'd0);
      check({tag, "_data_held"}, bus_if.rsp_data, v.rd);
   endtask

   vec_t vecs [11];

   initial begin
      int          lat;
      logic [31:0] rd;
      logic [2:0]  pc;
      bit          rok;
      bit          saw_valid;
      vec_t        v;

      n_cmp  = 0;
      n_fail = 0;
      bus_if.req_valid = 1'b0;
      bus_if.req_write = 1'b0;
      bus_if.req_mask  = '0;
      bus_if.req_addr  = '0;
      bus_if.req_data  = '0;

      //          wr    mask     addr          data          lat pc    rd
      vecs[0]  = '{1'b1, 4'b1111, 32'h03020100, 32'hA3A2A1A0, 2, 3'd1, 32'h00000000};
      vecs[1]  = '{1'b0, 4'b1111, 32'h03020100, 32'h00000000, 2, 3'd1, 32'hA3A2A1A0};
      vecs[2]  = '{1'b1, 4'b1111, 32'h0C080400, 32'h40302010, 5, 3'd4, 32'h00000000};
      vecs[3]  = '{1'b0, 4'b1111, 32'h0C080400, 32'h00000000, 5, 3'd4, 32'h40302010};
      vecs[4]  = '{1'b1, 4'b0001, 32'h00000010, 32'h0000005A, 2, 3'd1, 32'h00000000};
      vecs[5]  = '{1'b0, 4'b1111, 32'h10101010, 32'h00000000, 2, 3'd1, 32'h5A5A5A5A};
      vecs[6]  = '{1'b1, 4'b1111, 32'h20202020, 32'h44332211, 2, 3'd1, 32'h00000000};
      vecs[7]  = '{1'b0, 4'b1111, 32'h20202020, 32'h00000000, 2, 3'd1, 32'h44444444};
      vecs[8]  = '{1'b0, 4'b0000, 32'h03020100, 32'h00000000, 1, 3'd0, 32'h00000000};
      vecs[9]  = '{1'b0, 4'b0101, 32'h10021000, 32'h00000000, 2, 3'd1, 32'h00A20010};
      // Lanes 0 and 2 share 0x00 (broadcast), lane 1 conflicts in bank 0, lane 3 in bank 1.
      vecs[10] = '{1'b0, 4'b1111, 32'h01000400, 32'h00000000, 3, 3'd2, 32'hA1102010};

      reset = 1'b1;
      #2 reset = 1'b0;
      #2;
      check("reset_ready", 32'(bus_if.req_ready), 32'd0);
      check("reset_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
      check("reset_rsp_data", bus_if.rsp_data, 32'd0);
      check("reset_pass_count", 32'(bus_if.pass_count), 32'd0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;

      for (int i = 0; i < 11; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Next bundle offered in the same cycle rsp_valid is high.
      drive(vecs[5]);
      accept();
      wait_rsp(lat, rd, pc, rok);
      check("b2b_first_data", rd, 32'h5A5A5A5A);
      v = '{1'b0, 4'b1111, 32'h03020100, 32'h00000000, 2, 3'd1, 32'hA3A2A110};
      drive(v);
      check("b2b_ready_in_rsp_cycle", 32'(bus_if.req_ready), 32'd1);
      @(negedge clock);
      check("b2b_data_stable", bus_if.rsp_data, 32'h5A5A5A5A);
      accept();
      check("b2b_accepted", 32'(bus_if.req_ready), 32'd0);
      check("b2b_valid_fell", 32'(bus_if.rsp_valid), 32'd0);
      check("b2b_data_held", bus_if.rsp_data, 32'h5A5A5A5A);
      wait_rsp(lat, rd, pc, rok);
      check("b2b_second_latency", 32'(lat), 32'd2);
      check("b2b_second_data", rd, v.rd);
      @(posedge clock);
      #1;

      // Reset between E2 and E3 of a 4-pass write: only passes 1 and 2 commit.
      v = '{1'b1, 4'b1111, 32'h3C383430, 32'h04030201, 5, 3'd4, 32'h00000000};
      drive(v);
      accept();
      @(posedge clock);
      @(posedge clock);
      #2 reset = 1'b0;
      #1;
      check("rst_mid_ready", 32'(bus_if.req_ready), 32'd0);
      check("rst_mid_valid", 32'(bus_if.rsp_valid), 32'd0);
      check("rst_mid_rsp_data", bus_if.rsp_data, 32'd0);
      check("rst_mid_pass_count", 32'(bus_if.pass_count), 32'd0);
      for (int k = 0; k < 2; k++) begin
         @(posedge clock);
         #1;
         check("rst_hold_ready", 32'(bus_if.req_ready), 32'd0);
      end
      @(negedge clock);
      reset = 1'b1;
      saw_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clock);
         #1;
         if (bus_if.rsp_valid) saw_valid = 1'b1;
      end
      check("rst_no_rsp_valid", 32'(saw_valid), 32'd0);
      v = '{1'b0, 4'b0011, 32'h00003430, 32'h00000000, 3, 3'd2, 32'h00000201};
      run_vec(v, "rst_readback");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, want finished");
      $fatal(1, "timeout");
   end

endmodule
